miyajiro_mem_arbiter: RTL and testbench

Arbiter and sequencer that shares the single-port memory of `MIYAJIRO_CPU` between the instruction-fetch (IF) and load/store (LS) requesters. It accepts one request at a time over a valid/ready handshake and drives the memory with a fixed-latency protocol. It returns exactly one response pulse per accepted request to the requester that issued it. It sits between the CPU core and the memory model, in the same clock domain as the core.

---
 rtl/miyajiro_pkg.sv | 14 +
 rtl/miyajiro_mem_arbiter_if.sv | 48 ++++
 rtl/miyajiro_arb_pick.sv | 37 +++
 rtl/miyajiro_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_miyajiro_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/miyajiro_pkg.sv
// rtl/miyajiro_pkg.sv - shared types and constants for the miyajiro memory arbiter
package miyajiro_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

  localparam logic ARB_PORT_IF = 1'b0;
  localparam logic ARB_PORT_LS = 1'b1;

endpackage

// File: rtl/miyajiro_mem_arbiter_if.sv
// rtl/miyajiro_mem_arbiter_if.sv - request/response and memory command bundle of the arbiter
interface miyajiro_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req_valid;
  logic [ADDR_W-1:0]     if_req_addr;
  logic                  if_req_ready;
  logic                  if_rsp_valid;
  logic [DATA_W-1:0]     if_rsp_data;

  logic                  ls_req_valid;
  logic                  ls_req_we;
  logic [ADDR_W-1:0]     ls_req_addr;
  logic [DATA_W-1:0]     ls_req_wdata;
  logic [DATA_W/8-1:0]   ls_req_wstrb;
  logic                  ls_req_ready;
  logic                  ls_rsp_valid;
  logic [DATA_W-1:0]     ls_rsp_data;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;

  // Environment side: CPU requesters plus the memory model
  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata, ls_req_wstrb,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );

  // Arbiter side
  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata, ls_req_wstrb,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

endinterface

// File: rtl/miyajiro_arb_pick.sv
// rtl/miyajiro_arb_pick.sv - winner selection between IF and LS; MIYAJIRO_ARB_RR_EN selects round-robin
module miyajiro_arb_pick
  import miyajiro_pkg::*;
(
  input  logic i_if_valid,
  input  logic i_ls_valid,
  input  logic i_last_grant,
  output logic o_grant_valid,
  output logic o_grant_port
);

  assign o_grant_valid = i_if_valid | i_ls_valid;

`ifdef MIYAJIRO_ARB_RR_EN
  // On contention grant the port that did not win last time; a lone requester always wins
  always_comb begin
    o_grant_port = ARB_PORT_IF;
    if (i_if_valid && i_ls_valid) begin
      o_grant_port = ~i_last_grant;
    end else if (i_ls_valid) begin
      o_grant_port = ARB_PORT_LS;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last_grant;

  // Fixed priority: LS beats IF
  always_comb begin
    o_grant_port = ARB_PORT_IF;
    if (i_ls_valid) begin
      o_grant_port = ARB_PORT_LS;
    end
  end
`endif

endmodule

// File: rtl/miyajiro_mem_arbiter.sv
// rtl/miyajiro_mem_arbiter.sv - single-outstanding IF/LS memory arbiter; MIYAJIRO_ARB_RR_EN enables round-robin
module miyajiro_mem_arbiter
  import miyajiro_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  miyajiro_mem_arbiter_if.slave  bus
);

  localparam int CNT_W  = $clog2(MEM_LAT + 1);
  localparam int STRB_W = DATA_W / 8;

  arb_state_t          r_state;
  arb_state_t          w_next_state;

  logic                r_port;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rsp_data;

  logic                w_grant_valid;
  logic                w_grant_port;
  logic                w_last_grant;
  logic                w_hs;

  miyajiro_arb_pick u_pick (
    .i_if_valid    (bus.if_req_valid),
    .i_ls_valid    (bus.ls_req_valid),
    .i_last_grant  (w_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_port  (w_grant_port)
  );

  // The granted requester sees ready in the same cycle, so any grant in IDLE is a handshake
  assign w_hs = (r_state == ARB_IDLE) && w_grant_valid;

`ifdef MIYAJIRO_ARB_RR_EN
  logic r_last_grant;

  // Remember who won the most recent handshake; starts at IF so LS wins the first contention
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= ARB_PORT_IF;
    end else if (w_hs) begin
      r_last_grant <= w_grant_port;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = ARB_PORT_IF;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: accept, issue for one cycle, wait out the memory latency, respond for one cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE:  if (w_hs) w_next_state = ARB_ISSUE;
      ARB_ISSUE: w_next_state = ARB_WAIT;
      ARB_WAIT:  if (r_cnt == CNT_W'(1)) w_next_state = ARB_RESP;
      ARB_RESP:  w_next_state = ARB_IDLE;
      default:   w_next_state = ARB_IDLE;
    endcase
  end

  // Request latch, latency counter and response capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_port     <= ARB_PORT_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_hs) begin
            r_port <= w_grant_port;
            if (w_grant_port == ARB_PORT_LS) begin
              r_we    <= bus.ls_req_we;
              r_addr  <= bus.ls_req_addr;
              r_wdata <= bus.ls_req_wdata;
              r_wstrb <= bus.ls_req_wstrb;
            end else begin
              r_we    <= 1'b0;
              r_addr  <= bus.if_req_addr;
              r_wdata <= '0;
              r_wstrb <= '0;
            end
          end
        end
        ARB_ISSUE: begin
          r_cnt <= CNT_W'(MEM_LAT);
        end
        ARB_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_rsp_data <= r_we ? '0 : bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: ready only in IDLE (and never under reset), memory command only in ISSUE, response only in RESP
  always_comb begin
    bus.if_req_ready = 1'b0;
    bus.ls_req_ready = 1'b0;
    bus.if_rsp_valid = 1'b0;
    bus.if_rsp_data  = '0;
    bus.ls_rsp_valid = 1'b0;
    bus.ls_rsp_data  = '0;
    bus.mem_en       = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.mem_wstrb    = '0;
    case (r_state)
      ARB_IDLE: begin
        if (reset_n && w_grant_valid) begin
          if (w_grant_port == ARB_PORT_LS) begin
            bus.ls_req_ready = 1'b1;
          end else begin
            bus.if_req_ready = 1'b1;
          end
        end
      end
      ARB_ISSUE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = r_we;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        bus.mem_wstrb = r_wstrb;
      end
      ARB_RESP: begin
        if (r_port == ARB_PORT_LS) begin
          bus.ls_rsp_valid = 1'b1;
          bus.ls_rsp_data  = r_rsp_data;
        end else begin
          bus.if_rsp_valid = 1'b1;
          bus.if_rsp_data  = r_rsp_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_miyajiro_mem_arbiter.sv
// tb/tb_miyajiro_mem_arbiter.sv - self-checking bench for miyajiro_mem_arbiter (honours MIYAJIRO_ARB_RR_EN)
module tb_miyajiro_mem_arbiter;

  localparam int LAT = 2;
`ifdef MIYAJIRO_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  miyajiro_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  miyajiro_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return {8'hA5, i, 8'h3C, ~i};
  endfunction

  // ---------------- memory model driving mem_rdata ----------------
  logic [31:0] tb_mem  [0:255];
  logic [31:0] mdl_mem [0:255];
  int          rd_due = -10;
  logic [7:0]  rd_idx = 8'd0;

  always @(negedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b]) tb_mem[bus.mem_addr[9:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end else begin
        rd_due = cyc + LAT;
        rd_idx = bus.mem_addr[9:2];
      end
    end
  end

  // Only the cycle mem_en+LAT carries real data; everything else is recognisable junk
  always @(posedge clk) begin
    #1;
    bus.mem_rdata = (cyc == rd_due) ? tb_mem[rd_idx] : (32'hBAD0_0000 | 32'(cyc[15:0]));
  end

  // ---------------- monitor for literal checks ----------------
  int          if_rsp_cyc = -1, ls_rsp_cyc = -1, mem_cyc = -1;
  logic [31:0] if_rsp_dat, ls_rsp_dat, mem_addr_s, mem_wdata_s;
  logic        mem_we_s;
  logic [3:0]  mem_wstrb_s;
  int          n_if_rsp = 0, n_ls_rsp = 0;
  logic        acc_port_q [$];
  int          acc_cyc_q  [$];

  always @(negedge clk) begin
    if (bus.if_rsp_valid === 1'b1) begin
      if_rsp_cyc = cyc; if_rsp_dat = bus.if_rsp_data; n_if_rsp++;
    end
    if (bus.ls_rsp_valid === 1'b1) begin
      ls_rsp_cyc = cyc; ls_rsp_dat = bus.ls_rsp_data; n_ls_rsp++;
    end
    if (bus.mem_en === 1'b1) begin
      mem_cyc = cyc; mem_addr_s = bus.mem_addr; mem_we_s = bus.mem_we;
      mem_wdata_s = bus.mem_wdata; mem_wstrb_s = bus.mem_wstrb;
    end
    if (bus.ls_req_ready === 1'b1 && bus.ls_req_valid) begin
      acc_port_q.push_back(1'b1); acc_cyc_q.push_back(cyc);
    end
    if (bus.if_req_ready === 1'b1 && bus.if_req_valid) begin
      acc_port_q.push_back(1'b0); acc_cyc_q.push_back(cyc);
    end
  end

  // ---------------- transaction-level reference model + per-cycle compare ----------------
  logic        m_txn = 1'b0, m_last = 1'b0, m_port, m_we;
  int          m_acc = 0, m_free = 0;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic        e_ifr, e_lsr, e_en, e_we, e_ifv, e_lsv, win;
  logic [31:0] e_addr, e_wd, e_ifd, e_lsd;
  logic [3:0]  e_st;

  always @(negedge clk) begin
    {e_ifr, e_lsr, e_en, e_we, e_ifv, e_lsv} = '0;
    e_addr = '0; e_wd = '0; e_ifd = '0; e_lsd = '0; e_st = '0;
    if (!reset_n) begin
      m_txn = 1'b0; m_free = 0; m_last = 1'b0;
    end else begin
      if (cyc >= m_free && (bus.if_req_valid || bus.ls_req_valid)) begin
        if (bus.if_req_valid && bus.ls_req_valid) win = RR ? ~m_last : 1'b1;
        else win = bus.ls_req_valid;
        if (win) e_lsr = 1'b1; else e_ifr = 1'b1;
        m_txn = 1'b1; m_acc = cyc; m_free = cyc + LAT + 3; m_last = win; m_port = win;
        if (win) begin
          m_we = bus.ls_req_we; m_addr = bus.ls_req_addr;
          m_wdata = bus.ls_req_wdata; m_strb = bus.ls_req_wstrb;
        end else begin
          m_we = 1'b0; m_addr = bus.if_req_addr; m_wdata = '0; m_strb = '0;
        end
        if (m_we) begin
          for (int b = 0; b < 4; b++)
            if (m_strb[b]) mdl_mem[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
          m_rdata = '0;
        end else begin
          m_rdata = mdl_mem[m_addr[9:2]];
        end
      end
      if (m_txn && cyc == m_acc + 1) begin
        e_en = 1'b1; e_we = m_we; e_addr = m_addr; e_wd = m_wdata; e_st = m_strb;
      end
      if (m_txn && cyc == m_acc + 2 + LAT) begin
        if (m_port) begin e_lsv = 1'b1; e_lsd = m_rdata; end
        else        begin e_ifv = 1'b1; e_ifd = m_rdata; end
      end
    end
    chk("if_req_ready", 64'(bus.if_req_ready), 64'(e_ifr));
    chk("ls_req_ready", 64'(bus.ls_req_ready), 64'(e_lsr));
    chk("mem_en",       64'(bus.mem_en),       64'(e_en));
    chk("mem_we",       64'(bus.mem_we),       64'(e_we));
    chk("mem_addr",     64'(bus.mem_addr),     64'(e_addr));
    chk("mem_wdata",    64'(bus.mem_wdata),    64'(e_wd));
    chk("mem_wstrb",    64'(bus.mem_wstrb),    64'(e_st));
    chk("if_rsp_valid", 64'(bus.if_rsp_valid), 64'(e_ifv));
    chk("if_rsp_data",  64'(bus.if_rsp_data),  64'(e_ifd));
    chk("ls_rsp_valid", 64'(bus.ls_rsp_valid), 64'(e_lsv));
    chk("ls_rsp_data",  64'(bus.ls_rsp_data),  64'(e_lsd));
  end

  // ---------------- requester tasks ----------------
  task automatic do_if(input logic [31:0] a, output int acc);
    bus.if_req_addr = a; bus.if_req_valid = 1'b1; acc = -1;
    for (int k = 0; k < 40 && acc < 0; k++) begin
      @(negedge clk);
      if (bus.if_req_ready === 1'b1) acc = cyc;
    end
    if (acc < 0) begin
      n_checks++; n_errors++;
      $display("FAIL if_req timeout: got no ready, expected ready within 40 cycles");
    end
    @(posedge clk); #1;
    bus.if_req_valid = 1'b0; bus.if_req_addr = '0;
  endtask

  task automatic do_ls(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output int acc);
    bus.ls_req_we = we; bus.ls_req_addr = a; bus.ls_req_wdata = wd; bus.ls_req_wstrb = st;
    bus.ls_req_valid = 1'b1; acc = -1;
    for (int k = 0; k < 40 && acc < 0; k++) begin
      @(negedge clk);
      if (bus.ls_req_ready === 1'b1) acc = cyc;
    end
    if (acc < 0) begin
      n_checks++; n_errors++;
      $display("FAIL ls_req timeout: got no ready, expected ready within 40 cycles");
    end
    @(posedge clk); #1;
    bus.ls_req_valid = 1'b0; bus.ls_req_we = 1'b0; bus.ls_req_addr = '0;
    bus.ls_req_wdata = '0; bus.ls_req_wstrb = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the monitor has seen n accepts
  task automatic wait_accepts(input int n);
    for (int k = 0; k < 80 && acc_cyc_q.size() < n; k++) @(posedge clk);
    #1;
    if (acc_cyc_q.size() < n) begin
      n_checks++; n_errors++;
      $display("FAIL accept timeout: got %0d accepts, expected %0d", acc_cyc_q.size(), n);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int t, ti, tl, rc;
    logic [31:0] w;

    reset_n = 1'b0;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h100;
    bus.ls_req_valid = 1'b1; bus.ls_req_we = 1'b0; bus.ls_req_addr = 32'h300;
    bus.ls_req_wdata = '0;   bus.ls_req_wstrb = '0; bus.mem_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = init_word(8'(i)); mdl_mem[i] = init_word(8'(i));
    end
    tb_mem[64] = 32'hDEADBEEF; mdl_mem[64] = 32'hDEADBEEF;

    // Reset state: requests pending but nothing granted, all outputs low
    idle(3);
    chk("rst if_req_ready", 64'(bus.if_req_ready), 64'd0);
    chk("rst ls_req_ready", 64'(bus.ls_req_ready), 64'd0);
    chk("rst mem_en",       64'(bus.mem_en),       64'd0);
    chk("rst rsp_valid",    64'({bus.if_rsp_valid, bus.ls_rsp_valid}), 64'd0);
    bus.if_req_valid = 1'b0; bus.ls_req_valid = 1'b0;
    @(posedge clk); #2 reset_n = 1'b1;
    idle(1);

    // Single IF read of 0x100
    n_if_rsp = 0; n_ls_rsp = 0;
    do_if(32'h100, t);
    idle(8);
    chk("t1 mem_en cycle",  64'(mem_cyc),    64'(t + 1));
    chk("t1 mem_addr",      64'(mem_addr_s), 64'h100);
    chk("t1 if_rsp cycle",  64'(if_rsp_cyc), 64'(t + 4));
    chk("t1 if_rsp data",   64'(if_rsp_dat), 64'hDEADBEEF);
    chk("t1 if_rsp count",  64'(n_if_rsp),   64'd1);
    chk("t1 ls_rsp count",  64'(n_ls_rsp),   64'd0);

    // Simultaneous IF 0x200 / LS read 0x300: LS first
    fork
      do_if(32'h200, ti);
      do_ls(1'b0, 32'h300, 32'h0, 4'h0, tl);
    join
    idle(8);
    chk("t2 if accept", 64'(ti),         64'(tl + 5));
    chk("t2 ls rsp cyc", 64'(ls_rsp_cyc), 64'(tl + 4));
    chk("t2 if rsp cyc", 64'(if_rsp_cyc), 64'(tl + 9));
    chk("t2 ls data",   64'(ls_rsp_dat), 64'(init_word(8'd192)));
    chk("t2 if data",   64'(if_rsp_dat), 64'(init_word(8'd128)));

    // LS partial write, then read back
    do_ls(1'b1, 32'h40, 32'h12345678, 4'h3, t);
    idle(8);
    chk("t3 mem cycle", 64'(mem_cyc),     64'(t + 1));
    chk("t3 mem_we",    64'(mem_we_s),    64'd1);
    chk("t3 mem_addr",  64'(mem_addr_s),  64'h40);
    chk("t3 mem_wdata", 64'(mem_wdata_s), 64'h12345678);
    chk("t3 mem_wstrb", 64'(mem_wstrb_s), 64'h3);
    chk("t3 ls rsp cyc", 64'(ls_rsp_cyc), 64'(t + 4));
    chk("t3 ls data",   64'(ls_rsp_dat),  64'd0);
    do_ls(1'b0, 32'h40, 32'h0, 4'h0, t);
    idle(8);
    w = init_word(8'd16);
    chk("t3 readback",  64'(ls_rsp_dat),  64'({w[31:16], 16'h5678}));

    // Both held continuously (last grant set to IF first)
    do_if(32'h0C0, t);
    idle(6);
    acc_port_q.delete(); acc_cyc_q.delete();
    bus.if_req_addr = 32'h0C4; bus.if_req_valid = 1'b1;
    bus.ls_req_we = 1'b0; bus.ls_req_addr = 32'h0D0; bus.ls_req_valid = 1'b1;
    wait_accepts(4);
    bus.if_req_valid = 1'b0; bus.ls_req_valid = 1'b0;
    idle(8);
    if (acc_cyc_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("t4 grant port",  64'(acc_port_q[k]), 64'((k % 2 == 0) ? 1'b1 : !RR));
        chk("t4 grant cycle", 64'(acc_cyc_q[k]),  64'(acc_cyc_q[0] + 5 * k));
      end
    end

    // IF alone held: back-to-back every LAT+3 cycles
    acc_port_q.delete(); acc_cyc_q.delete();
    bus.if_req_addr = 32'h0E0; bus.if_req_valid = 1'b1;
    wait_accepts(3);
    bus.if_req_valid = 1'b0;
    idle(8);
    if (acc_cyc_q.size() >= 3) begin
      chk("t5 second accept", 64'(acc_cyc_q[1]), 64'(acc_cyc_q[0] + 5));
      chk("t5 third accept",  64'(acc_cyc_q[2]), 64'(acc_cyc_q[0] + 10));
    end

    // Reset during ARB_WAIT: outputs drop at once, aborted read never answers
    do_if(32'h180, t);
    n_if_rsp = 0; n_ls_rsp = 0;
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("t6 mem_en async",  64'(bus.mem_en), 64'd0);
    chk("t6 rsp async",     64'({bus.if_rsp_valid, bus.ls_rsp_valid}), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    rc = cyc;
    do_if(32'h100, t);
    idle(8);
    chk("t6 first accept", 64'(t),          64'(rc));
    chk("t6 if rsp cyc",   64'(if_rsp_cyc), 64'(t + 4));
    chk("t6 if data",      64'(if_rsp_dat), 64'hDEADBEEF);
    chk("t6 if rsp count", 64'(n_if_rsp),   64'd1);
    chk("t6 ls rsp count", 64'(n_ls_rsp),   64'd0);

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100us");
    $fatal(1);
  end

endmodule
